// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: frame layout, command encodings and the parity helper
// used by the receiver and the downstream decoder.
package bus_pkg;

   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      CMD_READ        = 2'b00,
      CMD_WRITE       = 2'b01,
      CMD_SPLIT_START = 2'b10,
      CMD_SPLIT_DATA  = 2'b11
   } cmd_e;

   // Field order is wire order: start is the first bit on the line (MSB).
   typedef struct packed {
      logic                  start;
      cmd_e                  cmd;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  parity;
      logic                  stop;
   } serial_frame_t;

   localparam int unsigned FRAME_BITS = $bits(serial_frame_t);

   function automatic logic calc_parity(input cmd_e                  cmd,
                                        input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [DATA_WIDTH-1:0] data,
                                        input logic                  odd);
      return (^{cmd, addr, data}) ^ odd;
   endfunction

endpackage

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame receiver: hunts for a start bit, shifts a serial_frame_t MSB first,
// checks parity and aborts frames that stall longer than TIMEOUT_CYCLES between strobes.
module frame_deserializer
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter bit          PARITY_ODD     = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          rx_bit_i,
   input  logic          rx_bit_valid_i,
   output logic          frame_valid_o,
   output serial_frame_t frame_o,
   output logic          parity_err_o,
   output logic          busy_o,
   output logic          timeout_o
);

   localparam int unsigned CNT_W = $clog2(FRAME_BITS);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_e;

   rx_state_e              state_q, state_d;
   logic [FRAME_BITS-2:0]  shreg_q;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic [TMO_W-1:0]       tmo_cnt_q;
   logic                   rx_en_q;

   logic                   strobe;
   logic                   last_bit;
   logic                   expired;
   logic                   start_load;
   logic                   shift_en;
   logic                   frame_done;
   logic                   abort;
   serial_frame_t          frame_next;

   // rx_en_q is low for the first edge after reset release, so a strobe there is ignored.
   assign strobe     = rx_bit_valid_i & rx_en_q;
   assign last_bit   = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
   assign expired    = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
   assign frame_next = serial_frame_t'({shreg_q, rx_bit_i});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE: begin
            if (strobe && rx_bit_i) state_d = RX_SHIFT;
         end
         RX_SHIFT: begin
            if (strobe && last_bit)      state_d = RX_IDLE;
            else if (!strobe && expired) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      start_load = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      abort      = 1'b0;
      busy_o     = 1'b0;
      case (state_q)
         RX_IDLE: begin
            start_load = strobe & rx_bit_i;
         end
         RX_SHIFT: begin
            busy_o     = 1'b1;
            shift_en   = strobe;
            frame_done = strobe & last_bit;
            abort      = ~strobe & expired;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_en_q       <= 1'b0;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         frame_valid_o <= 1'b0;
         timeout_o     <= 1'b0;
         frame_o       <= '0;
         parity_err_o  <= 1'b0;
      end else begin
         rx_en_q       <= 1'b1;
         frame_valid_o <= frame_done;
         timeout_o     <= abort;

         if (start_load) begin
            shreg_q   <= (FRAME_BITS - 1)'(1);
            bit_cnt_q <= CNT_W'(1);
         end else if (shift_en) begin
            shreg_q   <= frame_done ? '0 : {shreg_q[FRAME_BITS-3:0], rx_bit_i};
            bit_cnt_q <= frame_done ? '0 : bit_cnt_q + CNT_W'(1);
         end else if (abort) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
         end

         // Saturating idle counter, only meaningful while shifting.
         if (!busy_o || strobe || abort) begin
            tmo_cnt_q <= '0;
         end else if (!expired) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         end

         if (frame_done) begin
            frame_o      <= frame_next;
            parity_err_o <= calc_parity(frame_next.cmd, frame_next.addr, frame_next.data,
                                        PARITY_ODD) != frame_next.parity;
         end
      end
   end

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer: table of frames with hand-computed parity results,
// plus sequences for timeout, back-to-back frames and mid-frame reset.
module tb_frame_deserializer;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        rx_bit = 1'b0;
   logic        rx_bit_valid = 1'b0;

   logic        frame_valid, parity_err, busy, timeout;
   logic [28:0] frame;
   logic        frame_valid_odd, parity_err_odd, busy_odd, timeout_odd;
   logic [28:0] frame_odd;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_pulse = 0;
   int n_tmo = 0;
   int last_cyc = 0;
   int prev_cyc = 0;

   frame_deserializer #(.TIMEOUT_CYCLES(64), .PARITY_ODD(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .rx_bit_i(rx_bit), .rx_bit_valid_i(rx_bit_valid),
      .frame_valid_o(frame_valid), .frame_o(frame), .parity_err_o(parity_err),
      .busy_o(busy), .timeout_o(timeout));

   frame_deserializer #(.TIMEOUT_CYCLES(64), .PARITY_ODD(1'b1)) dut_odd (
      .clk_i(clk), .rst_ni(rst_ni), .rx_bit_i(rx_bit), .rx_bit_valid_i(rx_bit_valid),
      .frame_valid_o(frame_valid_odd), .frame_o(frame_odd), .parity_err_o(parity_err_odd),
      .busy_o(busy_odd), .timeout_o(timeout_odd));

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_valid) begin
         n_pulse++;
         prev_cyc = last_cyc;
         last_cyc = cyc;
      end
      if (timeout) n_tmo++;
   end

   typedef struct {
      logic [1:0]  cmd;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        par;
      logic        stop;
      int unsigned gap;
      int unsigned pre0;
      logic        err_even;
      logic        err_odd;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [28:0] pack(input vec_t v);
      return {1'b1, v.cmd, v.addr, v.data, v.par, v.stop};
   endfunction

   // Sends bits first..last-1 (0 = start bit); gap-1 idle cycles precede every strobe but bit 0.
   task automatic send_range(input logic [28:0] f, input int first, input int last,
                             input int unsigned gap);
      for (int i = first; i < last; i++) begin
         if (i > 0) repeat (gap - 1) tick();
         rx_bit_valid = 1'b1;
         rx_bit = f[28-i];
         tick();
         rx_bit_valid = 1'b0;
         rx_bit = 1'b0;
      end
   endtask

   task automatic check_frame(input string name, input logic [28:0] f,
                              input logic err_even, input logic err_odd);
      chk({name, "_valid"}, 32'(frame_valid), 32'd1);
      chk({name, "_frame"}, 32'(frame), 32'(f));
      chk({name, "_perr"}, 32'(parity_err), 32'(err_even));
      chk({name, "_perr_odd"}, 32'(parity_err_odd), 32'(err_odd));
      chk({name, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [28:0] f;
      logic [28:0] held;
      int p0;
      int t0;

      // Hand-computed: {cmd,addr,data} popcounts 10,10,10,16,3,10.
      vecs[0] = '{2'b01, 16'h1234, 8'hA5, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1};
      vecs[1] = '{2'b01, 16'h1234, 8'hA5, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0};
      vecs[2] = '{2'b01, 16'h1234, 8'hA5, 1'b0, 1'b1, 3, 10, 1'b0, 1'b1};
      vecs[3] = '{2'b00, 16'hFFFF, 8'h00, 1'b0, 1'b1, 2, 0, 1'b0, 1'b1};
      vecs[4] = '{2'b11, 16'h8000, 8'h00, 1'b1, 1'b0, 1, 0, 1'b0, 1'b1};
      vecs[5] = '{2'b10, 16'h00FF, 8'h80, 1'b1, 1'b1, 1, 3, 1'b1, 1'b0};

      // Reset state
      repeat (3) tick();
      chk("rst_valid", 32'(frame_valid), 32'd0);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      rst_ni = 1'b1;
      repeat (2) tick();

      // Table-driven frames
      for (int k = 0; k < 6; k++) begin
         f = pack(vecs[k]);
         p0 = n_pulse;
         if (vecs[k].pre0 > 0) begin
            repeat (vecs[k].pre0) begin
               rx_bit_valid = 1'b1;
               rx_bit = 1'b0;
               tick();
            end
            rx_bit_valid = 1'b0;
            chk($sformatf("v%0d_zeros_busy", k), 32'(busy), 32'd0);
            repeat (vecs[k].gap - 1) tick();
         end
         send_range(f, 0, 1, vecs[k].gap);
         chk($sformatf("v%0d_busy_start", k), 32'(busy), 32'd1);
         send_range(f, 1, 28, vecs[k].gap);
         chk($sformatf("v%0d_busy_pre_stop", k), 32'(busy), 32'd1);
         send_range(f, 28, 29, vecs[k].gap);
         check_frame($sformatf("v%0d", k), f, vecs[k].err_even, vecs[k].err_odd);
         tick();
         chk($sformatf("v%0d_valid_drop", k), 32'(frame_valid), 32'd0);
         chk($sformatf("v%0d_pulse_cnt", k), 32'(n_pulse - p0), 32'd1);
         repeat (3) tick();
      end

      // Timeout after 12 bits: expiry on the 65th idle edge
      held = frame;
      p0 = n_pulse;
      t0 = n_tmo;
      f = pack(vecs[3]);
      send_range(f, 0, 12, 1);
      repeat (64) tick();
      chk("tmo_not_yet", 32'(timeout), 32'd0);
      chk("tmo_busy_hold", 32'(busy), 32'd1);
      tick();
      chk("tmo_pulse", 32'(timeout), 32'd1);
      chk("tmo_busy_drop", 32'(busy), 32'd0);
      tick();
      chk("tmo_pulse_end", 32'(timeout), 32'd0);
      chk("tmo_frame_held", 32'(frame), 32'(held));
      chk("tmo_no_valid", 32'(n_pulse - p0), 32'd0);
      chk("tmo_pulse_cnt", 32'(n_tmo - t0), 32'd1);
      send_range(f, 0, 29, 1);
      check_frame("tmo_after", f, 1'b0, 1'b1);
      tick();

      // Strobe exactly in the expiry cycle wins
      t0 = n_tmo;
      f = pack(vecs[0]);
      send_range(f, 0, 12, 1);
      repeat (64) tick();
      send_range(f, 12, 29, 1);
      check_frame("tmo_edge", f, 1'b0, 1'b1);
      chk("tmo_edge_none", 32'(n_tmo - t0), 32'd0);
      tick();

      // Back-to-back frames
      p0 = n_pulse;
      f = {1'b1, 2'b01, 16'h0001, 8'h11, 1'b0, 1'b1};
      send_range(f, 0, 29, 1);
      check_frame("b2b_a", f, 1'b0, 1'b1);
      f = {1'b1, 2'b00, 16'hFFFF, 8'h00, 1'b0, 1'b1};
      send_range(f, 0, 29, 1);
      check_frame("b2b_b", f, 1'b0, 1'b1);
      tick();
      chk("b2b_pulses", 32'(n_pulse - p0), 32'd2);
      chk("b2b_spacing", 32'(last_cyc - prev_cyc), 32'd29);

      // Reset at bit 15, strobe in the release cycle ignored
      p0 = n_pulse;
      f = pack(vecs[1]);
      send_range(f, 0, 15, 1);
      rst_ni = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_frame", 32'(frame), 32'd0);
      chk("mrst_valid", 32'(frame_valid), 32'd0);
      chk("mrst_perr", 32'(parity_err), 32'd0);
      tick();
      rx_bit_valid = 1'b1;
      rx_bit = 1'b1;
      rst_ni = 1'b1;
      tick();
      rx_bit_valid = 1'b0;
      rx_bit = 1'b0;
      chk("mrst_release_ignored", 32'(busy), 32'd0);
      tick();
      send_range(f, 0, 29, 1);
      check_frame("mrst_after", f, 1'b1, 1'b0);
      tick();
      chk("mrst_pulses", 32'(n_pulse - p0), 32'd1);
      chk("mrst_no_timeout", 32'(timeout), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
